// File: rtl/ssvep_sample_frame_scheduler.sv
// ----------------------------------------------------------------------------
// ssvep_sample_frame_scheduler
//
// Moves ADS1299 conversion frames (NUM_CH parallel samples per DRDY) into the
// 32-bit Avalon-ST sink of the sampled-data FIFO, one channel word per beat.
// Adds capture enable, frame decimation, a bounded capture length and overrun
// accounting for frames that arrive while the previous frame is still being
// written out.
//
// Beat format : {ch_idx[3:0], seq[3:0], sample sign-extended to 24 bits}
// Header beat : {8'hA5, 4'h0, seq[3:0], frames_sent[15:0]}
//               (only when FRAME_HEADER_EN is defined)
//
// Build option:
//   FRAME_HEADER_EN  - when defined, every frame starts with one header beat,
//                      so a frame is NUM_CH+1 beats. Undefined: NUM_CH beats.
//
// Ports:
//   clock_i         system clock (also the FIFO write clock)
//   reset_i         synchronous, active-high reset
//   frame_valid_i   one-cycle pulse, new frame on frame_data_i
//   frame_data_i    NUM_CH samples, ch0 in the LSBs
//   enable_i        capture enable (level)
//   decim_i         keep one frame out of decim_i+1
//   num_frames_i    frames to capture, 0 = continuous
//   src_data_o      Avalon-ST data
//   src_valid_o     Avalon-ST valid
//   src_ready_i     Avalon-ST ready (ready latency 0)
//   busy_o          high while waiting for a frame or sending one
//   done_o          requested number of frames has been written
//   frames_sent_o   frames fully written since enable rose (wraps)
//   overrun_cnt_o   frames dropped while sending (saturates)
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | capture disabled, waiting for enable
// S_WAIT     | enabled, waiting for the next kept frame
// S_SEND     | streaming the held frame to the FIFO, one beat per transfer
// S_DONE     | num_frames reached, holding done until enable drops
// ----------------------------------------------------------------------------
module ssvep_sample_frame_scheduler #(
   parameter int NUM_CH   = 8,
   parameter int SAMPLE_W = 24,
   parameter int CNT_W    = 16
) (
   input  logic                         clock_i,
   input  logic                         reset_i,
   input  logic                         frame_valid_i,
   input  logic [NUM_CH*SAMPLE_W-1:0]   frame_data_i,
   input  logic                         enable_i,
   input  logic [7:0]                   decim_i,
   input  logic [CNT_W-1:0]             num_frames_i,
   output logic [31:0]                  src_data_o,
   output logic                         src_valid_o,
   input  logic                         src_ready_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic [CNT_W-1:0]             frames_sent_o,
   output logic [CNT_W-1:0]             overrun_cnt_o
);

`ifdef FRAME_HEADER_EN
   localparam int HDR_BEATS = 1;
`else
   localparam int HDR_BEATS = 0;
`endif
   localparam int NUM_BEATS = NUM_CH + HDR_BEATS;
   localparam int BEAT_W    = $clog2(NUM_BEATS + 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_SEND,
      S_DONE
   } state_t;

   state_t                       state_q, state_d;
   logic [NUM_CH*SAMPLE_W-1:0]   hold_q, hold_d;
   logic [BEAT_W-1:0]            beat_q, beat_d;
   logic [3:0]                   seq_q, seq_d;
   logic [7:0]                   decim_cnt_q, decim_cnt_d;
   logic [CNT_W-1:0]             frames_sent_q, frames_sent_d;
   logic [CNT_W-1:0]             overrun_cnt_q, overrun_cnt_d;

   logic                         xfer;
   logic                         last_xfer;
   logic                         keep_frame;
   logic [7:0]                   decim_next;
   logic [CNT_W-1:0]             frames_sent_inc;

   logic [3:0]                   ch_idx;
   logic [SAMPLE_W-1:0]          sample;
   logic [23:0]                  sample_ext;
   logic [31:0]                  chan_word;
   logic [31:0]                  beat_word;

   // ------------------------------------------------------------------------
   // Beat word generation. Everything is derived from registered state, so the
   // word stays stable for as long as the sink stalls.
   // ------------------------------------------------------------------------
`ifdef FRAME_HEADER_EN
   logic [31:0] hdr_word;

   // Beat 0 is the header, channel k rides on beat k+1.
   assign ch_idx   = 4'(beat_q - BEAT_W'(1));
   assign hdr_word = {8'hA5, 4'h0, seq_q, 16'(frames_sent_q)};
   assign beat_word = (beat_q == '0) ? hdr_word : chan_word;
`else
   assign ch_idx    = 4'(beat_q);
   assign beat_word = chan_word;
`endif

   always_comb begin
      sample = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_idx == 4'(i)) begin
            sample = hold_q[i*SAMPLE_W +: SAMPLE_W];
         end
      end
   end

   always_comb begin
      sample_ext = {24{sample[SAMPLE_W-1]}};
      sample_ext[SAMPLE_W-1:0] = sample;
   end

   assign chan_word = {ch_idx, seq_q, sample_ext};

   // ------------------------------------------------------------------------
   // Handshake and decimation helpers
   // ------------------------------------------------------------------------
   assign xfer            = (state_q == S_SEND) && src_ready_i;
   assign last_xfer       = xfer && (beat_q == LAST_BEAT);
   assign keep_frame      = (decim_cnt_q == 8'd0);
   assign decim_next      = (decim_cnt_q == decim_i) ? 8'd0 : decim_cnt_q + 8'd1;
   assign frames_sent_inc = frames_sent_q + CNT_W'(1);

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      hold_d        = hold_q;
      beat_d        = beat_q;
      seq_d         = seq_q;
      decim_cnt_d   = decim_cnt_q;
      frames_sent_d = frames_sent_q;
      overrun_cnt_d = overrun_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (enable_i) begin
               state_d       = S_WAIT;
               frames_sent_d = '0;
               overrun_cnt_d = '0;
               decim_cnt_d   = 8'd0;
            end
         end

         S_WAIT: begin
            if (!enable_i) begin
               state_d = S_IDLE;
            end else if (frame_valid_i) begin
               decim_cnt_d = decim_next;
               if (keep_frame) begin
                  hold_d  = frame_data_i;
                  beat_d  = '0;
                  state_d = S_SEND;
               end
            end
         end

         S_SEND: begin
            // The decimation phase tracks every frame on the wire, including
            // ones that end up dropped.
            if (frame_valid_i) begin
               decim_cnt_d = decim_next;
            end

            if (last_xfer) begin
               seq_d         = seq_q + 4'd1;
               frames_sent_d = frames_sent_inc;
               if ((num_frames_i != '0) && (frames_sent_inc == num_frames_i)) begin
                  state_d = S_DONE;
               end else if (!enable_i) begin
                  state_d = S_IDLE;
               end else if (frame_valid_i && keep_frame) begin
                  // A frame arriving on the final beat is picked up directly,
                  // so back-to-back frames stream without a gap.
                  hold_d = frame_data_i;
                  beat_d = '0;
               end else begin
                  state_d = S_WAIT;
               end
            end else begin
               if (xfer) begin
                  beat_d = beat_q + BEAT_W'(1);
               end
               if (frame_valid_i && (overrun_cnt_q != '1)) begin
                  overrun_cnt_d = overrun_cnt_q + CNT_W'(1);
               end
            end
         end

         S_DONE: begin
            if (!enable_i) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         hold_q        <= '0;
         beat_q        <= '0;
         seq_q         <= 4'd0;
         decim_cnt_q   <= 8'd0;
         frames_sent_q <= '0;
         overrun_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         hold_q        <= hold_d;
         beat_q        <= beat_d;
         seq_q         <= seq_d;
         decim_cnt_q   <= decim_cnt_d;
         frames_sent_q <= frames_sent_d;
         overrun_cnt_q <= overrun_cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign src_valid_o   = (state_q == S_SEND);
   assign src_data_o    = (state_q == S_SEND) ? beat_word : 32'd0;
   assign busy_o        = (state_q == S_WAIT) || (state_q == S_SEND);
   assign done_o        = (state_q == S_DONE);
   assign frames_sent_o = frames_sent_q;
   assign overrun_cnt_o = overrun_cnt_q;

endmodule
